// File: rtl/layer_out_deser_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_out_deser_if
//  Brief    : Generic valid/ready stream bundle. Carries either the serial
//             word stream into the deserialiser or its parallel vector output.
//  Revision : 1.0  initial release
// ============================================================================
interface layer_out_deser_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    // Producer side drives valid/data and observes ready
    modport master (output valid, output data, input ready);
    // Consumer side observes valid/data and drives ready
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/layer_out_deser.sv
`default_nettype none
// ============================================================================
//  Module   : layer_out_deser
//  Brief    : Collects M signed T-bit words from a layer's serial output and
//             presents them as one M*T-bit vector. Two ping-pong buffers keep
//             one word per cycle flowing while the consumer holds off.
//             Optional macro LAYER_DESER_RELU_EN clamps negative words to zero
//             as they are captured.
//  Revision : 1.0  initial release
// ============================================================================
module layer_out_deser #(
    parameter int M = 8,
    parameter int T = 16
) (
    input  logic               clk,
    input  logic               reset,
    layer_out_deser_if.slave   s_if,   // serial words in, W = T
    layer_out_deser_if.master  m_if    // packed vectors out, W = M*T
);
    localparam int             CW   = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0]  LAST = CW'(M - 1);

    logic [M*T-1:0] bufs [2];
    logic [1:0]     full;
    logic           wr_sel;
    logic           rd_sel;
    logic [CW-1:0]  cnt;
    logic [T-1:0]   word_in;
    logic           word_acc;
    logic           vec_acc;
    logic           last_word;

    // Handshakes decode from registered state only, so there is no
    // combinational path between the two ports.
    assign word_acc  = s_if.valid && !full[wr_sel];
    assign vec_acc   = m_if.ready && full[rd_sel];
    assign last_word = (cnt == LAST);

`ifdef LAYER_DESER_RELU_EN
    assign word_in = s_if.data[T-1] ? '0 : s_if.data;
`else
    assign word_in = s_if.data;
`endif

    assign s_if.ready = !full[wr_sel];
    assign m_if.valid = full[rd_sel];
    assign m_if.data  = bufs[rd_sel];

    // Word position counter and the write/read buffer pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (word_acc) begin
                if (last_word) begin
                    cnt    <= '0;
                    wr_sel <= ~wr_sel;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (vec_acc) begin
                rd_sel <= ~rd_sel;
            end
        end
    end

    generate
        for (genvar i = 0; i < 2; i++) begin : g_buf
            logic [M*T-1:0] buf_q;
            logic           full_q;

            // Lane capture and full flag for one half of the ping-pong pair;
            // a write and a drain never target the same half in one cycle.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    buf_q  <= '0;
                    full_q <= 1'b0;
                end else begin
                    if (word_acc && (wr_sel == 1'(i))) begin
                        for (int k = 0; k < M; k++) begin
                            if (cnt == CW'(k)) begin
                                buf_q[k*T +: T] <= word_in;
                            end
                        end
                        if (last_word) begin
                            full_q <= 1'b1;
                        end
                    end
                    if (vec_acc && (rd_sel == 1'(i))) begin
                        full_q <= 1'b0;
                    end
                end
            end

            assign bufs[i] = buf_q;
            assign full[i] = full_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_layer_out_deser.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_out_deser
//  Brief    : Self-checking bench for layer_out_deser: directed vector table,
//             backpressure / reset sequences and a random queue-model run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_out_deser;
    localparam int M      = 8;
    localparam int T      = 16;
    localparam int VW     = M * T;
    localparam int NV     = 2000;
    localparam int BUDGET = 60000;

`ifdef LAYER_DESER_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    layer_out_deser_if #(.W(T))  s_if ();
    layer_out_deser_if #(.W(VW)) m_if ();

    layer_out_deser #(.M(M), .T(T)) dut (
        .clk   (clk),
        .reset (reset),
        .s_if  (s_if),
        .m_if  (m_if)
    );

    typedef struct {
        string          name;
        logic [VW-1:0]  words;     // word k at [k*T +: T]
        logic [VW-1:0]  exp_raw;
        logic [VW-1:0]  exp_relu;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [VW+1:0] act, input logic [VW+1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [T-1:0] relu(input logic [T-1:0] w);
        return (RELU && w[T-1]) ? '0 : w;
    endfunction

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic send_vec(input logic [VW-1:0] words, input logic [VW-1:0] exp, input string nm);
        m_if.ready = 1'b1;
        for (int k = 0; k < M; k++) begin
            @(negedge clk);
            if (k == M - 1) check({nm, "_valid_before_last"}, m_if.valid, 1'b0);
            s_if.valid = 1'b1;
            s_if.data  = words[k*T +: T];
        end
        @(negedge clk);
        s_if.valid = 1'b0;
        s_if.data  = '0;
        check({nm, "_valid"}, m_if.valid, 1'b1);
        check({nm, "_data"}, m_if.data, exp);
        @(negedge clk);
        check({nm, "_valid_one_cycle"}, m_if.valid, 1'b0);
    endtask

    vec_t tbl [5];

    logic [VW-1:0] q [$];
    logic [VW-1:0] partial;
    int            pcnt;
    int            popped;
    int            cyc;
    int            w;
    logic          rdy;
    logic          sv, mr, wa, va;
    logic [T-1:0]  d;

    initial begin
        tbl[0] = '{"inc",   128'h0008_0007_0006_0005_0004_0003_0002_0001,
                            128'h0008_0007_0006_0005_0004_0003_0002_0001,
                            128'h0008_0007_0006_0005_0004_0003_0002_0001};
        tbl[1] = '{"lane3", 128'h0007_0006_0005_0004_FFFF_0002_0001_0000,
                            128'h0007_0006_0005_0004_FFFF_0002_0001_0000,
                            128'h0007_0006_0005_0004_0000_0002_0001_0000};
        tbl[2] = '{"mixed", 128'h8000_7FFF_FFFF_0001_8001_0000_1234_FEDC,
                            128'h8000_7FFF_FFFF_0001_8001_0000_1234_FEDC,
                            128'h0000_7FFF_0000_0001_0000_0000_1234_0000};
        tbl[3] = '{"neg_aa", {8{16'hAAAA}}, {8{16'hAAAA}}, 128'h0};
        tbl[4] = '{"pos_55", {8{16'h5555}}, {8{16'h5555}}, {8{16'h5555}}};

        reset      = 1'b1;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {s_if.ready, m_if.valid, m_if.data}, {1'b1, 1'b0, {VW{1'b0}}});
        end

        // Directed table
        for (int i = 0; i < 5; i++) begin
            send_vec(tbl[i].words, RELU ? tbl[i].exp_relu : tbl[i].exp_raw, tbl[i].name);
        end

        // Backpressure: 16 words fill both buffers, word 17 is held off
        @(negedge clk);
        m_if.ready = 1'b0;
        w          = 1;
        s_if.valid = 1'b1;
        s_if.data  = 16'(w);
        for (int c = 0; c < 20; c++) begin
            rdy = s_if.ready;
            @(negedge clk);
            if (rdy) begin
                w++;
                s_if.data = 16'(w);
            end
        end
        check("bp_accept_count", w, 17);
        check("bp_ready_low", s_if.ready, 1'b0);
        check("bp_v1_valid", m_if.valid, 1'b1);
        check("bp_v1_data", m_if.data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        m_if.ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_drain", s_if.ready, 1'b1);
        check("bp_v2_valid", m_if.valid, 1'b1);
        check("bp_v2_data", m_if.data, 128'h0010_000F_000E_000D_000C_000B_000A_0009);
        @(negedge clk);
        check("bp_drained", m_if.valid, 1'b0);
        for (int k = 18; k <= 24; k++) begin
            s_if.data = 16'(k);
            @(negedge clk);
        end
        s_if.valid = 1'b0;
        check("bp_v3_valid", m_if.valid, 1'b1);
        check("bp_v3_data", m_if.data, 128'h0018_0017_0016_0015_0014_0013_0012_0011);
        @(negedge clk);
        check("bp_v3_gone", m_if.valid, 1'b0);

        // Reset after 5 of 8 words
        for (int k = 0; k < 5; k++) begin
            s_if.valid = 1'b1;
            s_if.data  = 16'hAA01 + 16'(k);
            @(negedge clk);
        end
        s_if.valid = 1'b0;
        reset      = 1'b1;
        #1;
        check("rst_mid_state", {s_if.ready, m_if.valid, m_if.data}, {1'b1, 1'b0, {VW{1'b0}}});
        @(negedge clk);
        reset = 1'b0;
        send_vec(128'h0107_0106_0105_0104_0103_0102_0101_0100,
                 128'h0107_0106_0105_0104_0103_0102_0101_0100, "rst_mid");

        // Random traffic against a queue model
        q.delete();
        partial = '0;
        pcnt    = 0;
        popped  = 0;
        cyc     = 0;
        while (popped < NV && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            check("rnd_s_ready", s_if.ready, q.size() < 2);
            check("rnd_m_valid", m_if.valid, q.size() > 0);
            sv = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            d  = T'($urandom);
            s_if.valid = sv;
            s_if.data  = sv ? d : 'x;
            m_if.ready = mr;
            wa = sv && (q.size() < 2);
            va = mr && (q.size() > 0);
            if (va) begin
                check("rnd_data", m_if.data, q[0]);
                void'(q.pop_front());
                popped++;
            end
            if (wa) begin
                partial[pcnt*T +: T] = relu(d);
                pcnt++;
                if (pcnt == M) begin
                    q.push_back(partial);
                    pcnt = 0;
                end
            end
        end
        check("rnd_vectors_drained", popped, NV);
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
